pipeline_ctrl: RTL and testbench

- Central sequencing unit for the 5-stage MIPS pipeline.
- Drives enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC write enable.
- Arbitrates between dcache wait, branch/jump redirect, load-use hazards and icache miss bubbles.
- Runs the halt drain sequence. Sits beside the datapath and feeds every pipeline register interface.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline control state and
// the per-cycle control bundle driven onto the pipeline registers.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic en_if_id;
        logic en_id_ex;
        logic en_ex_mem;
        logic en_mem_wb;
        logic fl_if_id;
        logic fl_id_ex;
        logic fl_ex_mem;
        logic halt;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: EX-stage load destination against decode sources.
// Ports: ren_ex, rt_ex (EX load), rs_id, rt_id (decode sources) -> lu_hazard.
import cpu_types_pkg::*;

module hazard_detect (
    input  logic     ren_ex,
    input  regbits_t rt_ex,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    output logic     lu_hazard
);

    // $zero never creates a dependency
    assign lu_hazard = ren_ex && (rt_ex != '0) &&
                       ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC enable and halt drain.
// Ports: CLK, nRST (sync, active low), hit/hazard/redirect/halt inputs;
// pc_en, enable_*, flush_*, halt outputs. PIPE_PERF_EN adds stall_cnt
// and flush_cnt saturating counters.
import cpu_types_pkg::*;

module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     dmemREN_EX_MEM,
    input  logic     dmemWEN_EX_MEM,
    input  logic     pc_redirect_EX_MEM,
    input  logic     halt_EX_MEM,
    input  logic     dmemREN_ID_EX,
    input  regbits_t Rt_ID_EX,
    input  regbits_t Rs_IF_ID,
    input  regbits_t Rt_IF_ID,
    output logic     pc_en,
    output logic     enable_IF_ID,
    output logic     enable_ID_EX,
    output logic     enable_EX_MEM,
    output logic     enable_MEM_WB,
    output logic     flush_IF_ID,
    output logic     flush_ID_EX,
    output logic     flush_EX_MEM,
    output logic     halt
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    pipe_ctrl_state_t state, next_state;
    logic [DW-1:0]    drain_cnt, drain_next;
    pipe_ctrl_t       ctrl;
    logic             mem_pend;
    logic             lu_hazard;

    assign mem_pend = (dmemREN_EX_MEM | dmemWEN_EX_MEM) & ~dhit;

    hazard_detect u_hazard (
        .ren_ex    (dmemREN_ID_EX),
        .rt_ex     (Rt_ID_EX),
        .rs_id     (Rs_IF_ID),
        .rt_id     (Rt_IF_ID),
        .lu_hazard (lu_hazard)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        ctrl       = '0;
        next_state = state;
        drain_next = drain_cnt;
        unique case (state)
            RUN, MEMWAIT: begin
                next_state = RUN;
                if (mem_pend) begin
                    next_state = MEMWAIT;
                end else if (halt_EX_MEM) begin
                    // retire older work in WB, squash everything younger
                    ctrl.en_mem_wb = 1'b1;
                    ctrl.fl_if_id  = 1'b1;
                    ctrl.fl_id_ex  = 1'b1;
                    ctrl.fl_ex_mem = 1'b1;
                    next_state     = DRAIN;
                    drain_next     = DW'(DRAIN_CYCLES - 1);
                end else if (pc_redirect_EX_MEM) begin
                    ctrl = '{pc_en: 1'b1, en_if_id: 1'b1,
                             en_id_ex: 1'b1, en_ex_mem: 1'b1,
                             en_mem_wb: 1'b1, fl_if_id: 1'b1,
                             fl_id_ex: 1'b1, fl_ex_mem: 1'b1,
                             halt: 1'b0};
                end else if (lu_hazard) begin
                    // hold decode, bubble into EX; load moves on so
                    // the hazard clears after one cycle
                    ctrl.en_id_ex  = 1'b1;
                    ctrl.fl_id_ex  = 1'b1;
                    ctrl.en_ex_mem = 1'b1;
                    ctrl.en_mem_wb = 1'b1;
                end else if (!ihit) begin
                    ctrl.en_if_id  = 1'b1;
                    ctrl.fl_if_id  = 1'b1;
                    ctrl.en_id_ex  = 1'b1;
                    ctrl.en_ex_mem = 1'b1;
                    ctrl.en_mem_wb = 1'b1;
                end else begin
                    ctrl.pc_en     = 1'b1;
                    ctrl.en_if_id  = 1'b1;
                    ctrl.en_id_ex  = 1'b1;
                    ctrl.en_ex_mem = 1'b1;
                    ctrl.en_mem_wb = 1'b1;
                end
            end
            DRAIN: begin
                ctrl.en_mem_wb = 1'b1;
                if (drain_cnt == '0) begin
                    next_state = HALTED;
                end else begin
                    drain_next = drain_cnt - DW'(1);
                end
            end
            HALTED: begin
                ctrl.halt = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase
        // everything is quiet while reset is sampled
        if (!nRST) begin
            ctrl = '0;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign enable_IF_ID  = ctrl.en_if_id;
    assign enable_ID_EX  = ctrl.en_id_ex;
    assign enable_EX_MEM = ctrl.en_ex_mem;
    assign enable_MEM_WB = ctrl.en_mem_wb;
    assign flush_IF_ID   = ctrl.fl_if_id;
    assign flush_ID_EX   = ctrl.fl_id_ex;
    assign flush_EX_MEM  = ctrl.fl_ex_mem;
    assign halt          = ctrl.halt;

`ifdef PIPE_PERF_EN
    logic run_st, stall_ev, flush_ev;

    assign run_st   = (state == RUN) || (state == MEMWAIT);
    assign stall_ev = run_st & ~ctrl.pc_en;
    assign flush_ev = run_st & ~mem_pend & ~halt_EX_MEM &
                      pc_redirect_EX_MEM;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_ev && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl.
// Observed bundle: {pc_en, en IF/ID/EX/MEM, flush IF/ID/EX, halt}.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       nRST;
    logic       ihit, dhit;
    logic       dmemREN_EX_MEM, dmemWEN_EX_MEM;
    logic       pc_redirect_EX_MEM, halt_EX_MEM;
    logic       dmemREN_ID_EX;
    logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
    logic       pc_en, halt;
    logic       enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
    logic       flush_IF_ID, flush_ID_EX, flush_EX_MEM;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [8:0] P_ZERO  = 9'b0_0000_000_0;
    localparam logic [8:0] P_RUN   = 9'b1_1111_000_0;
    localparam logic [8:0] P_REDIR = 9'b1_1111_111_0;
    localparam logic [8:0] P_LU    = 9'b0_0111_010_0;
    localparam logic [8:0] P_IMISS = 9'b0_1111_100_0;
    localparam logic [8:0] P_HENT  = 9'b0_0001_111_0;
    localparam logic [8:0] P_DRAIN = 9'b0_0001_000_0;
    localparam logic [8:0] P_HALT  = 9'b0_0000_000_1;

    logic [8:0] obs;
    assign obs = {pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM,
                  enable_MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM,
                  halt};

    always #5 clk = ~clk;

    pipeline_ctrl #(.DRAIN_CYCLES(1), .CNT_W(32)) dut (
        .CLK                (clk),
        .nRST               (nRST),
        .ihit               (ihit),
        .dhit               (dhit),
        .dmemREN_EX_MEM     (dmemREN_EX_MEM),
        .dmemWEN_EX_MEM     (dmemWEN_EX_MEM),
        .pc_redirect_EX_MEM (pc_redirect_EX_MEM),
        .halt_EX_MEM        (halt_EX_MEM),
        .dmemREN_ID_EX      (dmemREN_ID_EX),
        .Rt_ID_EX           (Rt_ID_EX),
        .Rs_IF_ID           (Rs_IF_ID),
        .Rt_IF_ID           (Rt_IF_ID),
        .pc_en              (pc_en),
        .enable_IF_ID       (enable_IF_ID),
        .enable_ID_EX       (enable_ID_EX),
        .enable_EX_MEM      (enable_EX_MEM),
        .enable_MEM_WB      (enable_MEM_WB),
        .flush_IF_ID        (flush_IF_ID),
        .flush_ID_EX        (flush_ID_EX),
        .flush_EX_MEM       (flush_EX_MEM),
        .halt               (halt)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
`endif
    );

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0;
        dmemREN_EX_MEM = 1'b0; dmemWEN_EX_MEM = 1'b0;
        pc_redirect_EX_MEM = 1'b0; halt_EX_MEM = 1'b0;
        dmemREN_ID_EX = 1'b0;
        Rt_ID_EX = '0; Rs_IF_ID = '0; Rt_IF_ID = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== P_ZERO) begin
                fails++;
                $display("FAIL reset_hold%0d got=%b exp=%b", i, obs, P_ZERO);
            end
        end
        tick();
        nRST = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== P_RUN) begin
            fails++;
            $display("FAIL run_after_reset got=%b exp=%b", obs, P_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        dmemREN_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5;
        Rt_IF_ID = 5'd9;
        @(negedge clk);
        tests++;
        if (obs !== P_LU) begin
            fails++;
            $display("FAIL lu_rs got=%b exp=%b", obs, P_LU);
        end
        tick();
        idle();
        dmemREN_EX_MEM = 1'b1; dhit = 1'b1;
        Rs_IF_ID = 5'd5;
        @(negedge clk);
        tests++;
        if (obs !== P_RUN) begin
            fails++;
            $display("FAIL lu_after got=%b exp=%b", obs, P_RUN);
        end
        tick();
        idle();
        dmemREN_ID_EX = 1'b1; Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0;
        @(negedge clk);
        tests++;
        if (obs !== P_RUN) begin
            fails++;
            $display("FAIL lu_zero got=%b exp=%b", obs, P_RUN);
        end
        tick();
        Rt_ID_EX = 5'd7; Rs_IF_ID = 5'd3; Rt_IF_ID = 5'd7;
        @(negedge clk);
        tests++;
        if (obs !== P_LU) begin
            fails++;
            $display("FAIL lu_rt got=%b exp=%b", obs, P_LU);
        end
        tick();
        Rt_ID_EX = 5'd3; Rs_IF_ID = 5'd4; Rt_IF_ID = 5'd6;
        @(negedge clk);
        tests++;
        if (obs !== P_RUN) begin
            fails++;
            $display("FAIL lu_nomatch got=%b exp=%b", obs, P_RUN);
        end
        tick();
        idle();
    endtask

    task automatic test_memwait();
        for (int r = 0; r < 2; r++) begin
            idle();
            dmemWEN_EX_MEM = 1'b1;
            pc_redirect_EX_MEM = (r == 1);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                tests++;
                if (obs !== P_ZERO) begin
                    fails++;
                    $display("FAIL memwait r%0d c%0d got=%b exp=%b",
                             r, i, obs, P_ZERO);
                end
                tick();
            end
            dhit = 1'b1;
            @(negedge clk);
            tests++;
            if (obs !== ((r == 1) ? P_REDIR : P_RUN)) begin
                fails++;
                $display("FAIL memwait_dhit r%0d got=%b exp=%b", r, obs,
                         (r == 1) ? P_REDIR : P_RUN);
            end
            tick();
        end
        idle();
        @(negedge clk);
        tests++;
        if (obs !== P_RUN) begin
            fails++;
            $display("FAIL memwait_exit got=%b exp=%b", obs, P_RUN);
        end
        tick();
    endtask

    task automatic test_icache_miss();
        ihit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== P_IMISS) begin
                fails++;
                $display("FAIL imiss c%0d got=%b exp=%b", i, obs, P_IMISS);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_halt();
        halt_EX_MEM = 1'b1; pc_redirect_EX_MEM = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== P_HENT) begin
            fails++;
            $display("FAIL halt_entry got=%b exp=%b", obs, P_HENT);
        end
        tick();
        idle();
        @(negedge clk);
        tests++;
        if (obs !== P_DRAIN) begin
            fails++;
            $display("FAIL drain got=%b exp=%b", obs, P_DRAIN);
        end
        tick();
        pc_redirect_EX_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== P_HALT) begin
                fails++;
                $display("FAIL halted c%0d got=%b exp=%b", i, obs, P_HALT);
            end
            tick();
        end
        nRST = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== P_ZERO) begin
            fails++;
            $display("FAIL halt_in_reset got=%b exp=%b", obs, P_ZERO);
        end
        tick();
        nRST = 1'b1;
        idle();
        @(negedge clk);
        tests++;
        if (obs !== P_RUN) begin
            fails++;
            $display("FAIL halt_cleared got=%b exp=%b", obs, P_RUN);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        halt_EX_MEM = 1'b1;
        tick();
        idle();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== P_RUN) begin
            fails++;
            $display("FAIL reset_mid_drain got=%b exp=%b", obs, P_RUN);
        end
        tick();
    endtask

`ifdef PIPE_PERF_EN
    task automatic test_perf();
        nRST = 1'b0;
        idle();
        tick();
        nRST = 1'b1;
        @(negedge clk);
        tests++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL perf_reset got=%0d/%0d exp=0/0",
                     stall_cnt, flush_cnt);
        end
        ihit = 1'b0;
        repeat (4) tick();
        ihit = 1'b1; pc_redirect_EX_MEM = 1'b1;
        repeat (2) tick();
        idle();
        @(negedge clk);
        tests++;
        if (stall_cnt !== 32'd4 || flush_cnt !== 32'd2) begin
            fails++;
            $display("FAIL perf_count got=%0d/%0d exp=4/2",
                     stall_cnt, flush_cnt);
        end
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        @(negedge clk);
        tests++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL perf_clear got=%0d/%0d exp=0/0",
                     stall_cnt, flush_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_memwait();
        test_icache_miss();
        test_halt();
        test_reset_mid_drain();
`ifdef PIPE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
